id_stage: RTL and testbench

- Instruction decode stage, directly downstream of the fetch stage.
- Consumes the registered IF/ID pair (32-bit instruction, 64-bit PC) and decodes RV64I fields, the sign-extended immediate and the operation class.
- Reads the register file and detects load-use hazards against the EX stage.
- Registers all results into the ID/EX pipeline register that feeds execute.

---
 rtl/id_pkg.sv | 81 ++++++++
 rtl/id_decoder.sv | 181 ++++++++++++++++++
 rtl/id_stage.sv | 158 +++++++++++++++
 tb/tb_id_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// ============================================================================
// Module      : id_pkg
// Description : Shared types and constants for the instruction decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_pkg;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_ALU    = 4'd1,
        OP_ALUW   = 4'd2,
        OP_LOAD   = 4'd3,
        OP_STORE  = 4'd4,
        OP_BRANCH = 4'd5,
        OP_JAL    = 4'd6,
        OP_JALR   = 4'd7,
        OP_LUI    = 4'd8,
        OP_AUIPC  = 4'd9,
        OP_FENCE  = 4'd10,
        OP_SYSTEM = 4'd11
    } op_class_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM  = 7'h0f;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1b;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3b;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6f;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_decoder.sv
// ============================================================================
// Module      : id_decoder
// Description : Combinational RV64I decoder: class, ALU op, fields, immediate,
//               operand-use flags. ID_ILLEGAL_DETECT_EN exposes the illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decoder
    import id_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst_i,
    output logic [3:0]      op_class_o,
    output logic [3:0]      alu_op_o,
    output logic [2:0]      funct3_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic            rs1_used_o,
    output logic            rs2_used_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    op_class_e       w_cls;
    alu_op_e         w_aop;
    logic [XLEN-1:0] w_imm;
    logic            w_r1u, w_r2u, w_wr_rd, w_bad;

    assign w_opc = inst_i[6:0];
    assign w_f3  = inst_i[14:12];
    assign w_f7  = inst_i[31:25];

    assign w_imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign w_imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign w_imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};

    always_comb begin
        w_cls   = OP_NONE;
        w_aop   = ALU_ADD;
        w_imm   = '0;
        w_r1u   = 1'b0;
        w_r2u   = 1'b0;
        w_wr_rd = 1'b1;
        w_bad   = (inst_i[1:0] != 2'b11);
        case (w_opc)
            OPC_OP_IMM: begin
                w_cls = OP_ALU;
                w_imm = w_imm_i;
                w_r1u = 1'b1;
                w_aop = alu_from_funct3(w_f3, (w_f3 == F3_SR) && inst_i[30]);
                // 6-bit shamt on RV64: only the top six bits act as funct6
                if (w_f3 == F3_SLL && inst_i[31:26] != 6'h00) w_bad = 1'b1;
                if (w_f3 == F3_SR && inst_i[31:26] != 6'h00 && inst_i[31:26] != 6'h10)
                    w_bad = 1'b1;
            end
            OPC_OP: begin
                w_cls = OP_ALU;
                w_r1u = 1'b1;
                w_r2u = 1'b1;
                w_aop = alu_from_funct3(w_f3, inst_i[30]);
                if (w_f7 != 7'h00 &&
                    !(w_f7 == 7'h20 && (w_f3 == F3_ADD_SUB || w_f3 == F3_SR))) w_bad = 1'b1;
            end
            OPC_OP_IMM_32: begin
                w_cls = OP_ALUW;
                w_imm = w_imm_i;
                w_r1u = 1'b1;
                w_aop = alu_from_funct3(w_f3, (w_f3 == F3_SR) && inst_i[30]);
                case (w_f3)
                    F3_ADD_SUB: ;
                    F3_SLL:     if (w_f7 != 7'h00) w_bad = 1'b1;
                    F3_SR:      if (w_f7 != 7'h00 && w_f7 != 7'h20) w_bad = 1'b1;
                    default:    w_bad = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                w_cls = OP_ALUW;
                w_r1u = 1'b1;
                w_r2u = 1'b1;
                w_aop = alu_from_funct3(w_f3, inst_i[30]);
                case (w_f3)
                    F3_ADD_SUB, F3_SR: if (w_f7 != 7'h00 && w_f7 != 7'h20) w_bad = 1'b1;
                    F3_SLL:            if (w_f7 != 7'h00) w_bad = 1'b1;
                    default:           w_bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_cls = OP_LOAD;
                w_imm = w_imm_i;
                w_r1u = 1'b1;
                if (w_f3 == 3'd7) w_bad = 1'b1;
            end
            OPC_STORE: begin
                w_cls   = OP_STORE;
                w_imm   = w_imm_s;
                w_r1u   = 1'b1;
                w_r2u   = 1'b1;
                w_wr_rd = 1'b0;
                if (w_f3[2]) w_bad = 1'b1;
            end
            OPC_BRANCH: begin
                w_cls   = OP_BRANCH;
                w_imm   = w_imm_b;
                w_r1u   = 1'b1;
                w_r2u   = 1'b1;
                w_wr_rd = 1'b0;
                if (w_f3 == 3'd2 || w_f3 == 3'd3) w_bad = 1'b1;
            end
            OPC_JAL: begin
                w_cls = OP_JAL;
                w_imm = w_imm_j;
            end
            OPC_JALR: begin
                w_cls = OP_JALR;
                w_imm = w_imm_i;
                w_r1u = 1'b1;
                if (w_f3 != 3'd0) w_bad = 1'b1;
            end
            OPC_LUI: begin
                w_cls = OP_LUI;
                w_imm = w_imm_u;
            end
            OPC_AUIPC: begin
                w_cls = OP_AUIPC;
                w_imm = w_imm_u;
            end
            OPC_MISC_MEM: begin
                w_cls   = OP_FENCE;
                w_imm   = w_imm_i;
                w_wr_rd = 1'b0;
                if (w_f3[2:1] != 2'b00) w_bad = 1'b1;
            end
            OPC_SYSTEM: begin
                w_cls = OP_SYSTEM;
                w_imm = w_imm_i;
                // CSR immediate forms carry a uimm in the rs1 field
                w_r1u = !w_f3[2] && (w_f3 != 3'd0);
                if (w_f3 == 3'd4) w_bad = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_cls   = OP_NONE;
            w_aop   = ALU_ADD;
            w_imm   = '0;
            w_r1u   = 1'b0;
            w_r2u   = 1'b0;
            w_wr_rd = 1'b0;
        end
    end

    assign op_class_o = w_cls;
    assign alu_op_o   = w_aop;
    assign funct3_o   = w_f3;
    assign rd_o       = w_wr_rd ? inst_i[11:7] : 5'd0;
    assign rs1_o      = inst_i[19:15];
    assign rs2_o      = inst_i[24:20];
    assign rs1_used_o = w_r1u;
    assign rs2_used_o = w_r2u;
    assign imm_o      = w_imm;

`ifdef ID_ILLEGAL_DETECT_EN
    assign illegal_o = w_bad;
`else
    assign illegal_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : RV64I decode stage: regfile read, load-use hazard detection and
//               the ID/EX pipeline register. ID_ILLEGAL_DETECT_EN enables traps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage
    import id_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              clear,
    input  logic              bj_en,
    input  logic              trap_en,
    input  logic [31:0]       inst_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic [NREG_W-1:0] rs1_addr,
    output logic [NREG_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_rdata,
    input  logic [XLEN-1:0]   rs2_rdata,
    input  logic              ex_load,
    input  logic [NREG_W-1:0] ex_rd,
    output logic              hazard_stall,
    output logic              valid_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [3:0]        op_class,
    output logic [3:0]        alu_op,
    output logic [2:0]        funct3_out,
    output logic [NREG_W-1:0] rd_out,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   imm_out,
    output logic              illegal_out,
    output logic [31:0]       tval_out
);

    logic [3:0]        w_cls, w_aop;
    logic [2:0]        w_f3;
    logic [NREG_W-1:0] w_rd, w_rs1, w_rs2;
    logic              w_rs1_used, w_rs2_used, w_illegal, w_hazard;
    logic [XLEN-1:0]   w_imm;

    logic              valid_q,   valid_d;
    logic [XLEN-1:0]   pc_q,      pc_d;
    logic [3:0]        cls_q,     cls_d;
    logic [3:0]        aop_q,     aop_d;
    logic [2:0]        f3_q,      f3_d;
    logic [NREG_W-1:0] rd_q,      rd_d;
    logic [XLEN-1:0]   rs1_q,     rs1_d;
    logic [XLEN-1:0]   rs2_q,     rs2_d;
    logic [XLEN-1:0]   imm_q,     imm_d;
    logic              illegal_q, illegal_d;
    logic [31:0]       tval_q,    tval_d;

    id_decoder #(.XLEN(XLEN)) u_dec (
        .inst_i     (inst_in),
        .op_class_o (w_cls),
        .alu_op_o   (w_aop),
        .funct3_o   (w_f3),
        .rd_o       (w_rd),
        .rs1_o      (w_rs1),
        .rs2_o      (w_rs2),
        .rs1_used_o (w_rs1_used),
        .rs2_used_o (w_rs2_used),
        .imm_o      (w_imm),
        .illegal_o  (w_illegal)
    );

    assign rs1_addr = w_rs1;
    assign rs2_addr = w_rs2;

    assign w_hazard = ex_load && (ex_rd != '0) &&
                      ((w_rs1_used && (ex_rd == w_rs1)) || (w_rs2_used && (ex_rd == w_rs2)));
    assign hazard_stall = w_hazard;

    // Flush outranks stall; a stalled hazard holds rather than bubbles so the
    // load stays in EX and the hazard is re-evaluated next cycle.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        cls_d     = cls_q;
        aop_d     = aop_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        tval_d    = tval_q;
        if (clear || bj_en || trap_en || (!stall && w_hazard)) begin
            valid_d   = 1'b0;
            cls_d     = OP_NONE;
            rd_d      = '0;
            illegal_d = 1'b0;
        end else if (!stall) begin
            valid_d   = 1'b1;
            pc_d      = pc_in;
            cls_d     = w_cls;
            aop_d     = w_aop;
            f3_d      = w_f3;
            rd_d      = w_rd;
            rs1_d     = rs1_rdata;
            rs2_d     = rs2_rdata;
            imm_d     = w_imm;
            illegal_d = w_illegal;
            tval_d    = w_illegal ? inst_in : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            cls_q     <= OP_NONE;
            aop_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            illegal_q <= 1'b0;
            tval_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            cls_q     <= cls_d;
            aop_q     <= aop_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            tval_q    <= tval_d;
        end
    end

    assign valid_out   = valid_q;
    assign pc_out      = pc_q;
    assign op_class    = cls_q;
    assign alu_op      = aop_q;
    assign funct3_out  = f3_q;
    assign rd_out      = rd_q;
    assign rs1_data    = rs1_q;
    assign rs2_data    = rs2_q;
    assign imm_out     = imm_q;
    assign illegal_out = illegal_q;
    assign tval_out    = tval_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage (directed + random against a
//               reference decode model). Honours ID_ILLEGAL_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, clear, bj_en, trap_en, ex_load;
    logic [31:0] inst_in;
    logic [63:0] pc_in, rs1_rdata, rs2_rdata;
    logic [4:0]  ex_rd;
    logic [4:0]  rs1_addr, rs2_addr, rd_out;
    logic        hazard_stall, valid_out, illegal_out;
    logic [63:0] pc_out, rs1_data, rs2_data, imm_out;
    logic [3:0]  op_class, alu_op;
    logic [2:0]  funct3_out;
    logic [31:0] tval_out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  aop;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        u1;
        logic        u2;
        logic        ill;
    } dec_t;

    // Expected ID/EX contents
    logic        e_valid = 1'b0, e_ill = 1'b0;
    logic [63:0] e_pc = '0, e_r1 = '0, e_r2 = '0, e_imm = '0;
    logic [3:0]  e_cls = '0, e_aop = '0;
    logic [2:0]  e_f3 = '0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_tval = '0;

    id_stage #(.XLEN(64), .NREG_W(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear), .bj_en(bj_en),
        .trap_en(trap_en), .inst_in(inst_in), .pc_in(pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .ex_load(ex_load), .ex_rd(ex_rd), .hazard_stall(hazard_stall),
        .valid_out(valid_out), .pc_out(pc_out), .op_class(op_class),
        .alu_op(alu_op), .funct3_out(funct3_out), .rd_out(rd_out),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_out(imm_out),
        .illegal_out(illegal_out), .tval_out(tval_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] x);
        dec_t        r;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] sx, im_i, im_s, im_b, im_u, im_j, sgn;
        logic        legal;
        alu_op_e     tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        opc  = x[6:0];
        f3   = x[14:12];
        f7   = x[31:25];
        sx   = {{32{x[31]}}, x};
        sgn  = 64'($signed(sx) >>> 31);
        im_i = 64'($signed(sx) >>> 20);
        im_s = (im_i & ~64'h1f) | 64'(x[11:7]);
        im_b = (sgn << 12) | (64'(x[7]) << 11) | (64'(x[30:25]) << 5) | (64'(x[11:8]) << 1);
        im_u = sx & ~64'hfff;
        im_j = (sgn << 20) | (64'(x[19:12]) << 12) | (64'(x[20]) << 11) | (64'(x[30:21]) << 1);
        r     = '0;
        legal = (x[1:0] == 2'b11);
        case (opc)
            7'h13: begin r.cls = OP_ALU; r.imm = im_i; r.u1 = 1;
                   if (f3 == 1) legal &= (x[31:26] == 0);
                   if (f3 == 5) legal &= (x[31:26] == 0 || x[31:26] == 6'h10); end
            7'h33: begin r.cls = OP_ALU; r.u1 = 1; r.u2 = 1;
                   legal &= (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
            7'h1b: begin r.cls = OP_ALUW; r.imm = im_i; r.u1 = 1;
                   legal &= (f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 7'h20)); end
            7'h3b: begin r.cls = OP_ALUW; r.u1 = 1; r.u2 = 1;
                   legal &= ((f3 == 0 || f3 == 5) && (f7 == 0 || f7 == 7'h20)) || (f3 == 1 && f7 == 0); end
            7'h03: begin r.cls = OP_LOAD; r.imm = im_i; r.u1 = 1; legal &= (f3 != 7); end
            7'h23: begin r.cls = OP_STORE; r.imm = im_s; r.u1 = 1; r.u2 = 1; legal &= (f3 < 4); end
            7'h63: begin r.cls = OP_BRANCH; r.imm = im_b; r.u1 = 1; r.u2 = 1;
                   legal &= (f3 != 2 && f3 != 3); end
            7'h6f: begin r.cls = OP_JAL; r.imm = im_j; end
            7'h67: begin r.cls = OP_JALR; r.imm = im_i; r.u1 = 1; legal &= (f3 == 0); end
            7'h37: begin r.cls = OP_LUI; r.imm = im_u; end
            7'h17: begin r.cls = OP_AUIPC; r.imm = im_u; end
            7'h0f: begin r.cls = OP_FENCE; r.imm = im_i; legal &= (f3 < 2); end
            7'h73: begin r.cls = OP_SYSTEM; r.imm = im_i; r.u1 = (f3 inside {1, 2, 3});
                   legal &= (f3 != 4); end
            default: legal = 0;
        endcase
        r.aop = tbl[f3];
        if (f3 == 0 && opc[5] && x[30]) r.aop = ALU_SUB;
        if (f3 == 5 && x[30]) r.aop = ALU_SRA;
        if (!legal) begin
            r.cls = OP_NONE; r.u1 = 0; r.u2 = 0; r.imm = '0;
        end
        r.ill = !legal;
        r.rd  = (r.cls inside {OP_NONE, OP_STORE, OP_BRANCH, OP_FENCE}) ? 5'd0 : x[11:7];
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [13];
        logic [31:0] w;
        int          k;
        opcs = '{7'h13, 7'h33, 7'h1b, 7'h3b, 7'h03, 7'h23, 7'h63,
                 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 13) w[6:0] = opcs[k];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // One clock: check combinational outputs, advance the model, check ID/EX.
    task automatic cyc();
        dec_t d;
        logic hz;
        #1;
        d  = ref_dec(inst_in);
        hz = ex_load && (ex_rd != 0) &&
             ((d.u1 && ex_rd == inst_in[19:15]) || (d.u2 && ex_rd == inst_in[24:20]));
        chk("hazard_stall", 64'(hazard_stall), 64'(hz));
        chk("rs1_addr", 64'(rs1_addr), 64'(inst_in[19:15]));
        chk("rs2_addr", 64'(rs2_addr), 64'(inst_in[24:20]));
        @(posedge clk);
        if (rst) begin
            e_valid = 0; e_pc = 0; e_cls = OP_NONE; e_aop = 0; e_f3 = 0; e_rd = 0;
            e_r1 = 0; e_r2 = 0; e_imm = 0; e_ill = 0; e_tval = 0;
        end else if (clear || bj_en || trap_en || (!stall && hz)) begin
            e_valid = 0; e_cls = OP_NONE; e_rd = 0; e_ill = 0;
        end else if (!stall) begin
            e_valid = 1; e_pc = pc_in; e_cls = d.cls; e_aop = d.aop; e_f3 = inst_in[14:12];
            e_rd = d.rd; e_r1 = rs1_rdata; e_r2 = rs2_rdata; e_imm = d.imm;
`ifdef ID_ILLEGAL_DETECT_EN
            e_ill = d.ill; e_tval = d.ill ? inst_in : 32'h0;
`else
            e_ill = 0; e_tval = 0;
`endif
        end
        #1;
        chk("valid_out", 64'(valid_out), 64'(e_valid));
        chk("op_class", 64'(op_class), 64'(e_cls));
        chk("rd_out", 64'(rd_out), 64'(e_rd));
        chk("illegal_out", 64'(illegal_out), 64'(e_ill));
        if (e_ill) chk("tval_out", 64'(tval_out), 64'(e_tval));
        if (e_valid) begin
            chk("pc_out", pc_out, e_pc);
            chk("funct3_out", 64'(funct3_out), 64'(e_f3));
            chk("rs1_data", rs1_data, e_r1);
            chk("rs2_data", rs2_data, e_r2);
            if (e_cls != OP_NONE) chk("imm_out", imm_out, e_imm);
            if (e_cls == OP_ALU || e_cls == OP_ALUW) chk("alu_op", 64'(alu_op), 64'(e_aop));
        end
    endtask

    task automatic ctl_idle();
        rst = 0; stall = 0; clear = 0; bj_en = 0; trap_en = 0; ex_load = 0; ex_rd = 0;
    endtask

    task automatic load_valid(input logic [31:0] x, input logic [63:0] pc);
        ctl_idle();
        inst_in = x; pc_in = pc; rs1_rdata = 64'h11; rs2_rdata = 64'h22;
        cyc();
    endtask

    initial begin
        ctl_idle();
        rst = 1; inst_in = NOP_INST; pc_in = '0; rs1_rdata = '0; rs2_rdata = '0;
        cyc();
        cyc();
        chk("reset_pc", pc_out, 64'h0);
        chk("reset_imm", imm_out, 64'h0);
        chk("reset_rs1", rs1_data, 64'h0);
        chk("reset_tval", 64'(tval_out), 64'h0);
        chk("reset_aluop", 64'(alu_op), 64'h0);

        // ADDI x5,x1,-1
        ctl_idle();
        inst_in = 32'hfff08293; pc_in = 64'h80000000; rs1_rdata = 64'd7; rs2_rdata = 64'd0;
        cyc();
        chk("addi_valid", 64'(valid_out), 64'h1);
        chk("addi_class", 64'(op_class), 64'(OP_ALU));
        chk("addi_rd", 64'(rd_out), 64'd5);
        chk("addi_imm", imm_out, 64'hffffffffffffffff);
        chk("addi_rs1", rs1_data, 64'd7);
        chk("addi_pc", pc_out, 64'h80000000);

        // NOP is a real ADD, not a bubble
        load_valid(NOP_INST, 64'h100);
        chk("nop_valid", 64'(valid_out), 64'h1);
        chk("nop_aluop", 64'(alu_op), 64'(ALU_ADD));

        // ADD x4,x3,x2 behind a load to x3
        ctl_idle();
        inst_in = 32'h00218233; pc_in = 64'h104; ex_load = 1; ex_rd = 5'd3;
        #1;
        chk("hz_add_comb", 64'(hazard_stall), 64'h1);
        cyc();
        chk("hz_bubble", 64'(valid_out), 64'h0);
        ex_load = 0;
        cyc();
        chk("hz_release", 64'(valid_out), 64'h1);
        chk("hz_add_rd", 64'(rd_out), 64'd4);

        // LUI x3 never reads registers
        ctl_idle();
        inst_in = 32'h123451b7; ex_load = 1; ex_rd = 5'd3;
        cyc();
        chk("lui_imm", imm_out, 64'h0000000012345000);

        // Stall and hazard together: hold, no bubble
        load_valid(32'hfff08293, 64'h200);
        inst_in = 32'h00218233; stall = 1; ex_load = 1; ex_rd = 5'd3;
        cyc();
        chk("stall_hz_hold", 64'(valid_out), 64'h1);

        // Flush beats stall
        load_valid(32'hfff08293, 64'h300);
        stall = 1; bj_en = 1;
        cyc();
        chk("flush_vs_stall", 64'(valid_out), 64'h0);

        // Stall alone holds for three cycles while inputs change
        load_valid(32'h00a00393, 64'h400);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            inst_in = rand_inst(); pc_in = {$urandom, $urandom};
            rs1_rdata = {$urandom, $urandom};
            cyc();
        end
        chk("stall_pc", pc_out, 64'h400);
        chk("stall_imm", imm_out, 64'd10);

        // Reset mid-stream
        load_valid(32'hfff08293, 64'h500);
        rst = 1;
        cyc();
        chk("midrst_valid", 64'(valid_out), 64'h0);
        chk("midrst_pc", pc_out, 64'h0);
        chk("midrst_rs1", rs1_data, 64'h0);

        // All-zero word
        load_valid(32'h00000000, 64'h600);
        chk("zero_valid", 64'(valid_out), 64'h1);
        chk("zero_class", 64'(op_class), 64'(OP_NONE));
`ifdef ID_ILLEGAL_DETECT_EN
        chk("zero_illegal", 64'(illegal_out), 64'h1);
        chk("zero_tval", 64'(tval_out), 64'h0);
`else
        chk("zero_illegal", 64'(illegal_out), 64'h0);
`endif

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 20);
            clear     = ($urandom_range(0, 99) < 5);
            bj_en     = ($urandom_range(0, 99) < 5);
            trap_en   = ($urandom_range(0, 99) < 5);
            ex_load   = ($urandom_range(0, 1) == 1);
            ex_rd     = 5'($urandom_range(0, 3));
            inst_in   = rand_inst();
            pc_in     = {$urandom, $urandom};
            rs1_rdata = {$urandom, $urandom};
            rs2_rdata = {$urandom, $urandom};
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
